// File: rtl/mult_result_serializer_if.sv
// Handshake bundle between the multiplier, the serializer and the downstream pin mux.
// master = the side that feeds products in and drains bytes out; slave = the serializer.
interface mult_result_serializer_if #(
  parameter int PW = 48
);
  logic          in_valid;
  logic [PW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [7:0]    out_byte;
  logic          out_last;
  logic          out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_byte, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_byte, out_last
  );
endinterface

// File: rtl/mult_result_serializer.sv
// Buffers up to two PW-bit products and streams each out LSB-first as NB bytes,
// counting completed products in a wrapping 16-bit frame counter.
module mult_result_serializer #(
  parameter int PW = 48
) (
  input  logic                    clk,
  input  logic                    rst_n,
  mult_result_serializer_if.slave bus,
  output logic [15:0]             frame_cnt
);
  localparam int NB = PW / 8;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;

  logic [PW-1:0] r_mem [2];
  logic          r_wptr, r_rptr;
  logic [1:0]    r_cnt;
  logic [IW-1:0] r_idx;
  logic [15:0]   r_frame_cnt;

  logic [PW-1:0] w_head;
  logic          w_is_last, w_accept, w_xfer, w_pop;

  // Handshake outputs depend only on registered state, never on the valid/ready inputs.
  assign bus.in_ready  = (r_cnt != 2'd2);
  assign bus.out_valid = (r_cnt != 2'd0);
  assign w_head        = r_mem[r_rptr];
  assign bus.out_byte  = w_head[{r_idx, 3'b000} +: 8];
  assign w_is_last     = (r_idx == IW'(NB - 1));
  assign bus.out_last  = bus.out_valid & w_is_last;
  assign frame_cnt     = r_frame_cnt;

  assign w_accept = rst_n & bus.in_valid & bus.in_ready;
  assign w_xfer   = rst_n & bus.out_valid & bus.out_ready;
  assign w_pop    = w_xfer & w_is_last;

  // Storage needs no reset: an entry is only read once count says it was written.
  always_ff @(posedge clk) begin
    if (w_accept) r_mem[r_wptr] <= bus.in_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr      <= 1'b0;
      r_rptr      <= 1'b0;
      r_cnt       <= 2'd0;
      r_idx       <= '0;
      r_frame_cnt <= 16'd0;
    end else begin
      if (w_accept) r_wptr <= ~r_wptr;
      if (w_xfer) begin
        if (w_is_last) begin
          r_idx       <= '0;
          r_rptr      <= ~r_rptr;
          r_frame_cnt <= r_frame_cnt + 16'd1;
        end else begin
          r_idx <= r_idx + IW'(1);
        end
      end
      case ({w_accept, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_result_serializer.sv
// Random and directed stimulus against a queue-of-products reference model.
module tb_mult_result_serializer;
  localparam int PW = 48;
  localparam int NB = PW / 8;
  localparam logic [63:0] MASK = (64'd1 << PW) - 64'd1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] frame_cnt;

  mult_result_serializer_if #(.PW(PW)) bus();

  mult_result_serializer #(.PW(PW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: products waiting, bytes already sent of the head, frames done.
  logic [63:0] q[$];
  int          pos    = 0;
  logic [15:0] frames = 16'd0;
  bit          known  = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic [63:0] exp_byte;
    chk("in_ready",  64'(bus.in_ready),  64'(q.size() < 2));
    chk("out_valid", 64'(bus.out_valid), 64'(q.size() > 0));
    chk("out_last",  64'(bus.out_last),  64'(q.size() > 0 && pos == NB - 1));
    chk("frame_cnt", 64'(frame_cnt),     64'(frames));
    if (q.size() > 0) begin
      exp_byte = (q[0] >> (8 * pos)) & 64'hFF;
      chk("out_byte", 64'(bus.out_byte), exp_byte);
    end
  endtask

  // One clock: check outputs, drive inputs, then advance the model across the edge.
  task automatic step(input bit rn, input bit v, input logic [63:0] d, input bit rdy,
                      output bit acc);
    bit xf;
    @(negedge clk);
    if (known) check_outputs();
    rst_n         = rn;
    bus.in_valid  = v;
    bus.in_data   = d[PW-1:0];
    bus.out_ready = rdy;
    acc = rn && v && (q.size() < 2);
    xf  = rn && rdy && (q.size() > 0);
    @(posedge clk);
    if (!rn) begin
      q.delete();
      pos    = 0;
      frames = 16'd0;
      known  = 1'b1;
    end else begin
      if (xf) begin
        pos++;
        if (pos == NB) begin
          pos = 0;
          void'(q.pop_front());
          frames++;
        end
      end
      if (acc) q.push_back(d & MASK);
    end
  endtask

  function automatic logic [63:0] rnd48();
    return {$urandom, $urandom} & MASK;
  endfunction

  initial begin
    bit acc;
    logic [63:0] pend;
    int guard;
    rst_n = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;

    // Reset while inputs toggle; they must be ignored.
    step(0, 1, rnd48(), 1, acc);
    step(0, 1, rnd48(), 1, acc);
    step(1, 0, 0, 0, acc);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
    chk("rst_frame_cnt", 64'(frame_cnt),     64'd0);

    // Single product, continuous drain.
    step(1, 1, 64'h0102_0304_0506, 1, acc);
    for (int i = 0; i < 8; i++) step(1, 0, 0, 1, acc);
    chk("single_frames", 64'(frame_cnt), 64'd1);

    // Backpressure after byte 0x04.
    step(1, 1, 64'h0102_0304_0506, 1, acc);
    step(1, 0, 0, 1, acc);
    step(1, 0, 0, 1, acc);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, acc);
    @(negedge clk);
    chk("bp_hold_byte", 64'(bus.out_byte), 64'h04);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 1, acc);

    // Fill: A, B accepted, C stalls until A's last byte has popped.
    step(1, 1, 64'hAAAA_AAAA_AA01, 0, acc);
    step(1, 1, 64'hBBBB_BBBB_BB02, 0, acc);
    for (int i = 0; i < 4; i++) step(1, 1, 64'hCCCC_CCCC_CC03, 0, acc);
    guard = 0;
    acc = 1'b0;
    while (!acc && guard < 20) begin
      step(1, 1, 64'hCCCC_CCCC_CC03, 1, acc);
      guard++;
    end
    chk("c_accept_cycle", 64'(guard), 64'd7);
    for (int i = 0; i < 14; i++) step(1, 0, 0, 1, acc);

    // Back-to-back stream: push on the cycle the head's last byte leaves.
    for (int f = 0; f < 4; f++)
      for (int i = 0; i < NB; i++)
        step(1, (i == NB - 1), rnd48(), 1, acc);
    for (int i = 0; i < 2 * NB; i++) step(1, 0, 0, 1, acc);

    // Mid-product reset with a second product buffered.
    step(1, 1, 64'h1111_1111_1111, 1, acc);
    step(1, 1, 64'h2222_2222_2222, 1, acc);
    step(1, 0, 0, 1, acc);
    step(1, 0, 0, 1, acc);
    step(0, 1, rnd48(), 1, acc);
    @(negedge clk);
    chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_ready", 64'(bus.in_ready),  64'd1);
    for (int i = 0; i < 8; i++) step(1, 0, 0, 1, acc);

    // Random traffic; a product offered but refused is kept for the next try.
    pend = rnd48();
    for (int i = 0; i < 3000; i++) begin
      step(1, bit'($urandom_range(0, 1)), pend, $urandom_range(0, 3) != 0, acc);
      if (acc) pend = rnd48();
    end
    for (int i = 0; i < 3 * NB; i++) step(1, 0, 0, 1, acc);

    // Frame counter wrap: preload near the top, then finish three frames.
    @(negedge clk);
    force dut.r_frame_cnt = 16'hFFFD;
    #1 release dut.r_frame_cnt;
    frames = 16'hFFFD;
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < NB; i++)
        step(1, (i == 0), 64'h0000_0000_0001, 1, acc);
    for (int i = 0; i < 2; i++) step(1, 0, 0, 1, acc);
    @(negedge clk);
    chk("wrap_frame_cnt", 64'(frame_cnt), 64'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mult_result_serializer.md
MULT_RESULT_SERIALIZER -- requirements
Module: mult_result_serializer

Interface
REQ-001 SHALL have parameter: PW, default 48, product width in bits; legal values are multiples of 8, from 16 to 64.
REQ-002 SHALL define the derived constant NB = PW/8, the number of bytes per product.
REQ-003 SHALL have port: clk  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port: in_valid  input  1  upstream multiplier presents a finished product.
REQ-006 SHALL have port: in_data  input  PW  product value; sampled only on an accept.
REQ-007 SHALL have port: in_ready  output  1  block can accept a product this cycle.
REQ-008 SHALL have port: out_valid  output  1  out_byte holds a valid byte.
REQ-009 SHALL have port: out_byte  output  8  current byte of the head product, LSB-first.
REQ-010 SHALL have port: out_last  output  1  out_byte is byte NB-1 of its product.
REQ-011 SHALL have port: out_ready  input  1  downstream (pin mux) takes the byte.
REQ-012 SHALL have port: frame_cnt  output  16  count of fully emitted products.

Function
REQ-013 SHALL buffer products in a 2-entry FIFO; the entry count is 0..2, with read and write pointers of 1 bit each.
REQ-014 SHALL drive in_ready = (count != 2) combinationally from registered state only, never from in_valid.
REQ-015 SHALL define accept = in_valid & in_ready; on accept, in_data is written at the write pointer and the write pointer toggles.
REQ-016 SHALL drive out_valid = (count != 0), with no dependence on out_ready.
REQ-017 SHALL hold a byte index idx, range 0..NB-1, and drive out_byte = head[8*idx+7 : 8*idx].
REQ-018 SHALL drive out_last = out_valid & (idx == NB-1).
REQ-019 SHALL define xfer = out_valid & out_ready; on xfer with idx < NB-1, idx increments by 1.
REQ-020 SHALL, on xfer with idx == NB-1, set idx to 0, pop the head, toggle the read pointer, and increment frame_cnt modulo 2^16 (wraps 0xFFFF -> 0x0000).
REQ-021 SHALL keep out_byte, out_last and idx stable while out_valid=1 and out_ready=0.
REQ-022 SHALL, on accept and pop in the same cycle, leave count unchanged and update both pointers.
REQ-023 SHALL have a latency of 1 cycle: a product accepted in cycle t into an empty FIFO gives out_valid=1 with byte 0 in cycle t+1.
REQ-024 SHALL sustain one byte per cycle: with out_ready held at 1, NB consecutive cycles carry one product, and the next product follows with no bubble if it is already buffered.
REQ-025 SHALL, when count == 2, hold in_ready low even if a pop occurs in the same cycle; there is no full-bypass.
REQ-026 SHALL never alter a FIFO entry between its write and its pop.

Reset
REQ-027 SHALL, while rst_n == 0 at a rising clk edge, set count=0, both pointers=0, idx=0 and frame_cnt=0.
REQ-028 SHALL therefore give, in the cycle after reset: out_valid=0, out_last=0, in_ready=1, frame_cnt=0; out_byte value is don't-care.
REQ-029 SHALL, on reset asserted mid-product, discard the partial product and all buffered products; no further bytes of them appear.
REQ-030 SHALL ignore in_valid and out_ready in any cycle where rst_n == 0.

Verification (PW=48)
REQ-031 SHALL cover the single product case: accept 0x0102_0304_0506 with out_ready=1 -> bytes 06,05,04,03,02,01 in cycles t+1..t+6; out_last only at 01; frame_cnt=1.
REQ-032 SHALL cover backpressure: out_ready=0 for 5 cycles after byte 0x04 -> out_byte=0x04 and idx held; the remaining bytes resume in order once out_ready=1.
REQ-033 SHALL cover full: push A, B, C back-to-back with out_ready=0 -> A and B accepted, in_ready=0 with C stalled, and C accepted only in the cycle after A's last byte pops.
REQ-034 SHALL cover simultaneous push/pop: count=1, last byte transfers while a new product is accepted -> count stays 1, the next cycle shows byte 0 of the new product, no bubble.
REQ-035 SHALL cover frame_cnt wrap: force 65536 frames, e.g. 0x0000_0000_0001 repeated -> frame_cnt reads 0xFFFF, then 0x0000.
REQ-036 SHALL cover mid-product reset: assert rst_n=0 after 3 bytes of a product with a second product buffered -> out_valid=0 and in_ready=1 next cycle, and no leftover bytes appear after release.
